// File: rtl/sid_nibble_tx.sv
// Streams a captured 32-bit SID word MSB-first as hex nibbles with ASCII encoding,
// a per-frame nibble checksum and a completed-frame counter.
module sid_nibble_tx #(
  parameter bit SUPPRESS_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sid,
  input  logic        sid_valid,
  output logic        sid_ready,
  output logic [3:0]  digit,
  output logic [7:0]  digit_ascii,
  output logic        digit_valid,
  input  logic        digit_ready,
  output logic        digit_last,
  output logic [7:0]  checksum,
  output logic        busy,
  output logic [15:0] frame_count
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, state_next;
  logic [31:0] sreg;
  logic [3:0]  rem;
  logic [7:0]  csum;
  logic [15:0] frames;
  logic [2:0]  lz;
  logic        accept;
  logic        take;

  // Leading zero nibbles, capped so that at least one digit is always sent.
  function automatic logic [2:0] lead_zeros(input logic [31:0] w);
    logic [2:0] n;
    logic       done;
    n    = 3'd0;
    done = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (!done && (w[31-4*i -: 4] == 4'h0)) n = n + 3'd1;
      else done = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    state_next  = state;
    sid_ready   = (state == IDLE) && !rst;
    digit_valid = (state == SEND);
    busy        = (state == SEND);
    digit       = sreg[31:28];
    digit_ascii = to_ascii(sreg[31:28]);
    digit_last  = (state == SEND) && (rem == 4'd1);
    checksum    = csum;
    frame_count = frames;
    lz          = SUPPRESS_ZERO ? lead_zeros(sid) : 3'd0;
    accept      = sid_ready && sid_valid;
    take        = digit_valid && digit_ready;
    if (accept) state_next = SEND;
    else if (take && (rem == 4'd1)) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= 32'h0;
      rem    <= 4'd0;
      csum   <= 8'h0;
      frames <= 16'h0;
    end else begin
      state <= state_next;
      if (accept) begin
        sreg <= sid << {lz, 2'b00};
        rem  <= 4'd8 - {1'b0, lz};
        csum <= 8'h0;
      end else if (take) begin
        sreg <= sreg << 4;
        rem  <= rem - 4'd1;
        csum <= csum + {4'h0, sreg[31:28]};
        if (rem == 4'd1) frames <= frames + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sid_nibble_tx.sv
// Directed bench for sid_nibble_tx: one instance without and one with zero suppression.
module tb_sid_nibble_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sid;
  logic        sv;
  logic        dr;
  logic        sel;
  int          errors = 0;
  int          checks = 0;

  logic        d0_sid_ready, d0_digit_valid, d0_digit_last, d0_busy;
  logic [3:0]  d0_digit;
  logic [7:0]  d0_digit_ascii, d0_checksum;
  logic [15:0] d0_frame_count;
  logic        d1_sid_ready, d1_digit_valid, d1_digit_last, d1_busy;
  logic [3:0]  d1_digit;
  logic [7:0]  d1_digit_ascii, d1_checksum;
  logic [15:0] d1_frame_count;

  logic        o_sid_ready, o_digit_valid, o_digit_last, o_busy;
  logic [3:0]  o_digit;
  logic [7:0]  o_digit_ascii, o_checksum;
  logic [15:0] o_frame_count;

  always #5 clk = ~clk;

  sid_nibble_tx #(.SUPPRESS_ZERO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .sid(sid), .sid_valid(sv & ~sel), .sid_ready(d0_sid_ready),
    .digit(d0_digit), .digit_ascii(d0_digit_ascii), .digit_valid(d0_digit_valid),
    .digit_ready(dr), .digit_last(d0_digit_last), .checksum(d0_checksum),
    .busy(d0_busy), .frame_count(d0_frame_count)
  );

  sid_nibble_tx #(.SUPPRESS_ZERO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .sid(sid), .sid_valid(sv & sel), .sid_ready(d1_sid_ready),
    .digit(d1_digit), .digit_ascii(d1_digit_ascii), .digit_valid(d1_digit_valid),
    .digit_ready(dr), .digit_last(d1_digit_last), .checksum(d1_checksum),
    .busy(d1_busy), .frame_count(d1_frame_count)
  );

  assign o_sid_ready   = sel ? d1_sid_ready   : d0_sid_ready;
  assign o_digit_valid = sel ? d1_digit_valid : d0_digit_valid;
  assign o_digit_last  = sel ? d1_digit_last  : d0_digit_last;
  assign o_busy        = sel ? d1_busy        : d0_busy;
  assign o_digit       = sel ? d1_digit       : d0_digit;
  assign o_digit_ascii = sel ? d1_digit_ascii : d0_digit_ascii;
  assign o_checksum    = sel ? d1_checksum    : d0_checksum;
  assign o_frame_count = sel ? d1_frame_count : d0_frame_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, " digit"}, 32'(o_digit), 32'h0);
    chk({tag, " ascii"}, 32'(o_digit_ascii), 32'h30);
    chk({tag, " valid"}, 32'(o_digit_valid), 32'h0);
    chk({tag, " last"}, 32'(o_digit_last), 32'h0);
    chk({tag, " busy"}, 32'(o_busy), 32'h0);
    chk({tag, " sid_ready"}, 32'(o_sid_ready), 32'h0);
    chk({tag, " checksum"}, 32'(o_checksum), 32'h0);
    chk({tag, " frame_count"}, 32'(o_frame_count), 32'h0);
  endtask

  task automatic check_idle(input string tag, input logic [7:0] cs, input logic [15:0] fc);
    chk({tag, " idle valid"}, 32'(o_digit_valid), 32'h0);
    chk({tag, " idle busy"}, 32'(o_busy), 32'h0);
    chk({tag, " idle sid_ready"}, 32'(o_sid_ready), 32'h1);
    chk({tag, " checksum"}, 32'(o_checksum), 32'(cs));
    chk({tag, " frame_count"}, 32'(o_frame_count), 32'(fc));
  endtask

  // Called at a falling edge with the selected instance idle.
  task automatic frame(input string tag, input logic [31:0] s, input logic [31:0] exp_digits,
                       input int n, input logic [15:0] pat, input logic [7:0] cs,
                       input logic [15:0] fc);
    int idx;
    int cyc;
    logic [3:0] ed;
    sid = s;
    sv  = 1'b1;
    @(negedge clk);
    sv  = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 40) begin
      dr = pat[cyc % 16];
      ed = exp_digits[31-4*idx -: 4];
      chk({tag, " valid"}, 32'(o_digit_valid), 32'h1);
      chk({tag, " busy"}, 32'(o_busy), 32'h1);
      chk({tag, " sid_ready"}, 32'(o_sid_ready), 32'h0);
      chk({tag, " digit"}, 32'(o_digit), 32'(ed));
      chk({tag, " ascii"}, 32'(o_digit_ascii), 32'(asc(ed)));
      chk({tag, " last"}, 32'(o_digit_last), 32'(idx == n - 1));
      if (dr) idx++;
      cyc++;
      @(negedge clk);
    end
    chk({tag, " digits sent"}, 32'(idx), 32'(n));
    dr = 1'b1;
    check_idle(tag, cs, fc);
  endtask

  initial begin
    rst = 1'b1;
    sid = 32'h0;
    sv  = 1'b0;
    dr  = 1'b0;
    sel = 1'b0;
    @(negedge clk);
    check_reset_outputs("init reset");
    rst = 1'b0;
    @(negedge clk);
    chk("post reset sid_ready", 32'(o_sid_ready), 32'h1);

    frame("plain", 32'h1234ABCD, 32'h1234ABCD, 8, 16'hFFFF, 8'h38, 16'd1);
    frame("backpressure", 32'h1234ABCD, 32'h1234ABCD, 8, 16'b1001_1010_0110_1001, 8'h38, 16'd2);

    sel = 1'b1;
    @(negedge clk);
    frame("sz F0", 32'h000000F0, 32'hF0000000, 2, 16'hFFFF, 8'h0F, 16'd1);
    frame("sz zero", 32'h00000000, 32'h00000000, 1, 16'hFFFF, 8'h00, 16'd2);

    // Abandon a frame three digits in; nothing of it may be counted.
    sel = 1'b0;
    @(negedge clk);
    sid = 32'hFFFFFFFF;
    sv  = 1'b1;
    dr  = 1'b1;
    @(negedge clk);
    sv  = 1'b0;
    repeat (3) @(negedge clk);
    chk("midframe digit", 32'(o_digit), 32'hF);
    chk("midframe valid", 32'(o_digit_valid), 32'h1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after reset sid_ready", 32'(o_sid_ready), 32'h1);
    chk("after reset frame_count", 32'(o_frame_count), 32'h0);
    frame("sid one", 32'h00000001, 32'h00000001, 8, 16'hFFFF, 8'h01, 16'd1);

    // sid_valid held high: one capture per IDLE cycle, mid-frame sid changes ignored.
    sid = 32'h12345678;
    sv  = 1'b1;
    dr  = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) sid = 32'h9ABCDEF0;
      chk("hold valid", 32'(o_digit_valid), 32'(c % 9 != 0));
      if (c < 9) chk("hold digit f1", 32'(o_digit), 32'(4'(32'h12345678 >> (4 * (8 - c)))));
      if (c > 9 && c < 18) chk("hold digit f2", 32'(o_digit), 32'(4'(32'h9ABCDEF0 >> (4 * (17 - c)))));
      if (c == 9) chk("hold fc1", 32'(o_frame_count), 32'd2);
      if (c == 18) chk("hold fc2", 32'(o_frame_count), 32'd3);
    end
    sv = 1'b0;
    @(negedge clk);

    force dut0.frames = 16'hFFFF;
    @(negedge clk);
    release dut0.frames;
    chk("preload frame_count", 32'(o_frame_count), 32'hFFFF);
    frame("wrap", 32'h1234ABCD, 32'h1234ABCD, 8, 16'hFFFF, 8'h38, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
